// File: rtl/adder_seq_ctrl_pkg.sv
// adder_seq_ctrl_pkg: shared state encoding and slice width for the nibble-serial adder
package adder_seq_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
  localparam int NIBBLE_W = 4;
endpackage

// File: rtl/adder_seq_ctrl_fa4_slice.sv
// fa4_slice: combinational 4-bit adder slice with carry in/out
module fa4_slice
  import adder_seq_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
endmodule

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: nibble-serial adder reusing one 4-bit slice, LSB nibble first
module adder_seq_ctrl
  import adder_seq_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   busy,
  output logic                   done
);
  localparam int WIDTH = NIBBLE_W * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
  state_t              state;
  logic [IW-1:0]       idx;
  logic                carry;
  logic                co;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [NIBBLE_W-1:0] s;
  fa4_slice u_slice (
    .a  (a_q[idx*NIBBLE_W +: NIBBLE_W]),
    .b  (b_q[idx*NIBBLE_W +: NIBBLE_W]),
    .cin(carry),
    .s  (s),
    .co (co)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            sum   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          sum[idx*NIBBLE_W +: NIBBLE_W] <= s;
          carry <= co;
          if (idx == LAST) begin
            cout  <= co;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: directed vector table plus multi-cycle corner sequences for adder_seq_ctrl
module tb_adder_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic [15:0] sum;
  logic        cout, busy, done;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
  } vec_t;
  vec_t v[8];
  adder_seq_ctrl #(.NIBBLES(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout),
    .busy (busy),
    .done (done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic do_op(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                       output int n, output int bc);
    @(negedge clk);
    a = va;
    b = vb;
    cin = vc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    bc = 0;
    while (!done && n < 20) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
  endtask
  initial begin
    int n, bc;
    int t1, t2, t3, k;
    logic [15:0] s1, s2;
    v[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    v[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    v[2] = '{16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b1};
    v[3] = '{16'h8000, 16'h7FFF, 1'b0, 16'hFFFF, 1'b0};
    v[4] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};
    v[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    v[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    v[7] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};
    start = 1'b1;
    a = 16'hFFFF;
    b = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("reset_sum", 32'(sum), 32'h0);
    chk("reset_flags", {29'b0, cout, busy, done}, 32'h0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {29'b0, cout, busy, done}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      do_op(v[i].a, v[i].b, v[i].cin, n, bc);
      chk($sformatf("vec%0d_lat", i), 32'(n), 32'd4);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'd4);
      chk($sformatf("vec%0d_sum", i), 32'(sum), 32'(v[i].s));
      chk($sformatf("vec%0d_cout", i), 32'(cout), 32'(v[i].co));
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'h0);
      chk($sformatf("vec%0d_sum_hold", i), 32'({cout, sum}), 32'({v[i].co, v[i].s}));
    end
    @(negedge clk);
    a = 16'h1234;
    b = 16'h1111;
    cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'hFFFF;
    b = 16'hFFFF;
    cin = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 2;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("run_ignore_lat", 32'(n), 32'd4);
    chk("run_ignore_sum", 32'({cout, sum}), 32'h02345);
    k = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || done) k++;
    end
    chk("run_ignore_no_extra", 32'(k), 32'd0);
    chk("run_ignore_hold", 32'(sum), 32'h2345);
    @(negedge clk);
    a = 16'h1234;
    b = 16'h1111;
    start = 1'b1;
    cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_partial", 32'(sum), 32'h0005);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_sum", 32'(sum), 32'h0);
    chk("abort_flags", {29'b0, cout, busy, done}, 32'h0);
    k = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) k++;
    end
    chk("abort_no_done", 32'(k), 32'd0);
    rst_n = 1'b1;
    do_op(16'h00FF, 16'h0001, 1'b0, n, bc);
    chk("after_abort_lat", 32'(n), 32'd4);
    chk("after_abort_sum", 32'({cout, sum}), 32'h00100);
    @(negedge clk);
    @(negedge clk);
    a = 16'h0001;
    b = 16'h0002;
    cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    a = 16'h0010;
    t1 = -1;
    t2 = -1;
    t3 = -1;
    s1 = '0;
    s2 = '0;
    for (int c = 0; c < 16; c++) begin
      if (done) begin
        if (t1 < 0) begin
          t1 = c;
          s1 = sum;
        end else if (t2 < 0) begin
          t2 = c;
          s2 = sum;
        end else if (t3 < 0) t3 = c;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b_first_done", 32'(t1), 32'd4);
    chk("b2b_gap1", 32'(t2 - t1), 32'd5);
    chk("b2b_gap2", 32'(t3 - t2), 32'd5);
    chk("b2b_sum1", 32'(s1), 32'h0003);
    chk("b2b_sum2", 32'(s2), 32'h0012);
    repeat (8) @(negedge clk);
    chk("b2b_idle", {29'b0, cout, busy, done}, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_seq_ctrl.md
ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit slices per operand; WIDTH = 4*NIBBLES.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to add a, b, cin; sampled on rising edge.
REQ-006 a  input  WIDTH  operand A, unsigned.
REQ-007 b  input  WIDTH  operand B, unsigned.
REQ-008 cin  input  1  carry-in to nibble 0.
REQ-009 sum  output  WIDTH  registered result, held until next accepted start.
REQ-010 cout  output  1  registered carry-out of top nibble.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  one-cycle pulse, high in DONE only.

Function
REQ-013 The block SHALL share one 4-bit adder slice across all nibbles, computing one nibble per clock, LSB nibble first.
REQ-014 States SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-015 IDLE: start=1 at edge -> latch a, b, cin; clear sum; nibble index=0; go RUN.
REQ-016 RUN: each edge writes slice result into sum[4*idx+3:4*idx], stores slice carry as next carry, increments idx.
REQ-017 RUN: on edge processing idx=NIBBLES-1, load cout from slice carry, go DONE.
REQ-018 Latency: sum/cout/done valid exactly NIBBLES edges after the edge accepting start (4 for default).
REQ-019 DONE: lasts one cycle; start=1 -> accept as in IDLE (back-to-back) and go RUN; else go IDLE.
REQ-020 start while in RUN SHALL be ignored; latched operands SHALL not change.
REQ-021 Operand inputs SHALL only be sampled on the accepting edge; later changes SHALL not affect result.
REQ-022 sum and cout SHALL hold their values in IDLE and DONE; sum updates only in RUN.
REQ-023 Arithmetic: {cout,sum} SHALL equal a+b+cin modulo 2^(WIDTH+1); carry wraps no further.
REQ-024 Nibble index SHALL be wide enough for NIBBLES-1 and SHALL never exceed it.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, sum=0, cout=0, busy=0, done=0, idx=0, internal carry=0, latched operands=0.
REQ-026 Reset mid-RUN SHALL abort the operation with no done pulse; next start after release SHALL run normally.
REQ-027 start asserted during reset SHALL be ignored; first edge after deassertion may accept it.

Structure
REQ-028 Shared package SHALL hold state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and constant NIBBLE_W=4.
REQ-029 One combinational sub-module fa4_slice (a[3:0], b[3:0], cin -> s[3:0], co) SHALL be instantiated exactly once.
REQ-030 Operand nibble selection SHALL be via indexed part-select of the latched operands, no per-nibble adder copies.

Verification
REQ-031 a=0x0000, b=0x0000, cin=0, start -> after 4 edges sum=0x0000, cout=0, done high one cycle, busy high 4 cycles.
REQ-032 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all 4 nibbles).
REQ-033 a=0x8000, b=0x7FFF, cin=1 -> sum=0x0000, cout=1; with cin=0 -> sum=0xFFFF, cout=0.
REQ-034 start 0x1234+0x1111, change a/b and pulse start during RUN -> sum=0x2345, cout=0, no extra operation.
REQ-035 rst_n low at 2nd RUN edge -> all outputs 0 immediately, no done; then 0x00FF+0x0001 -> sum=0x0100.
REQ-036 start held high across DONE -> second operation begins without IDLE cycle; done pulses every 5 cycles.
